// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM access controller.
//   mem_state_t        : controller FSM states
//   SRAM_ADDR_W/DATA_W : external half-word SRAM geometry
//   DEFAULT_BASE_ADDR  : byte address that maps to SRAM word 0
//   word_index()       : byte address -> 17-bit SRAM word index (wraps)
package mem_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdLo = 3'd1,
    StRdHi = 3'd2,
    StWrLo = 3'd3,
    StWrHi = 3'd4,
    StDone = 3'd5
  } mem_state_t;

  // No range check: anything outside the SRAM window simply wraps.
  function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [31:0] addr,
                                                        input logic [31:0] base);
    logic [31:0] diff;
    diff = addr - base;
    return (SRAM_ADDR_W-1)'(diff >> 2);
  endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Bus bundle between the MEM stage, the controller and the SRAM pads.
//   MEM side : rd_en, wr_en, address, write_data -> read_data, ready, freeze
//   SRAM side: sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n <- sram_dq_in
// Modports: slave = controller view, master = pipeline/SRAM environment view.
interface mem_access_controller_if;
  import mem_ctrl_pkg::*;

  logic                   rd_en;
  logic                   wr_en;
  logic [31:0]            address;
  logic [31:0]            write_data;
  logic [31:0]            read_data;
  logic                   ready;
  logic                   freeze;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [SRAM_DATA_W-1:0] sram_dq_out;
  logic                   sram_dq_oe;
  logic [SRAM_DATA_W-1:0] sram_dq_in;
  logic                   sram_we_n;
  logic                   sram_oe_n;

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

endinterface

// File: rtl/sram_phase_timer.sv
// Per-phase wait counter, counting 0..WAIT_CYCLES-1 while run is high.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count back to 0
//   run      : a half-word phase is in progress
//   last     : final cycle of the current phase (count wraps to 0 next edge)
module sram_phase_timer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic last
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastVal = CntW'(WAIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last = run && (cnt_q == LastVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM phases of
// WAIT_CYCLES each, freezing the pipeline until the access reaches DONE.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_access_controller_if.slave (MEM handshake + SRAM pads)
//   perf_*   : only with MEM_CTRL_PERF_EN defined; saturating 16-bit counters
//              of completed reads, completed writes and frozen cycles.
// Parameters: WAIT_CYCLES (>= 1) cycles per half-word phase, BASE_ADDR byte
// address of SRAM word 0.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_access_controller_if.slave  bus
`ifdef MEM_CTRL_PERF_EN
  ,
  output logic [15:0]             perf_rd_count,
  output logic [15:0]             perf_wr_count,
  output logic [15:0]             perf_stall_count
`endif
);

  mem_state_t              state_q, state_d;
  logic [SRAM_ADDR_W-2:0]  idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q;
  logic                    phase_run;
  logic                    phase_last;
  logic                    rd_phase;
  logic                    wr_phase;
  logic                    hi_phase;
  logic                    req;
  logic                    ready;

  assign rd_phase  = (state_q == StRdLo) || (state_q == StRdHi);
  assign wr_phase  = (state_q == StWrLo) || (state_q == StWrHi);
  assign hi_phase  = (state_q == StRdHi) || (state_q == StWrHi);
  assign phase_run = rd_phase || wr_phase;

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!phase_run),
    .run   (phase_run),
    .last  (phase_last)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        // Read wins if the decoder ever raises both requests.
        if (bus.rd_en || bus.wr_en) begin
          state_d = bus.rd_en ? StRdLo : StWrLo;
          idx_d   = word_index(bus.address, BASE_ADDR);
          wdata_d = bus.write_data;
        end
      end
      StRdLo:  if (phase_last) state_d = StRdHi;
      StRdHi:  if (phase_last) state_d = StDone;
      StWrLo:  if (phase_last) state_d = StWrHi;
      StWrHi:  if (phase_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      if (rd_phase && phase_last) begin
        if (hi_phase) rdata_q[31:16] <= bus.sram_dq_in;
        else          rdata_q[15:0]  <= bus.sram_dq_in;
      end
    end
  end

  // Pad outputs come from registered state and latched request only.
  always_comb begin
    bus.sram_addr   = {idx_q, hi_phase};
    bus.sram_dq_out = '0;
    if (wr_phase) begin
      bus.sram_dq_out = hi_phase ? wdata_q[31:16] : wdata_q[15:0];
    end
    bus.sram_dq_oe = wr_phase;
    bus.sram_we_n  = !wr_phase;
    bus.sram_oe_n  = !rd_phase;
  end

  assign req           = bus.rd_en || bus.wr_en;
  assign ready         = ((state_q == StIdle) && !req) || (state_q == StDone);
  assign bus.ready     = ready;
  assign bus.freeze    = req && !ready;
  assign bus.read_data = rdata_q;

`ifdef MEM_CTRL_PERF_EN
  logic rd_finish;
  logic wr_finish;

  assign rd_finish = (state_q == StRdHi) && phase_last;
  assign wr_finish = (state_q == StWrHi) && phase_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_count    <= '0;
      perf_wr_count    <= '0;
      perf_stall_count <= '0;
    end else begin
      if (rd_finish && (perf_rd_count != 16'hFFFF)) perf_rd_count <= perf_rd_count + 16'd1;
      if (wr_finish && (perf_wr_count != 16'hFFFF)) perf_wr_count <= perf_wr_count + 16'd1;
      if (bus.freeze && (perf_stall_count != 16'hFFFF)) begin
        perf_stall_count <= perf_stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: a W=2 instance exercised cycle by cycle
// and a W=1 instance for the short-phase case (and perf counters when
// MEM_CTRL_PERF_EN is defined). Expected load words go through a scoreboard
// queue built from the bench's own reference copy of SRAM contents.
module tb_mem_access_controller;

  localparam int W0 = 2;
  localparam int W1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_controller_if bus0 ();
  mem_access_controller_if bus1 ();

`ifdef MEM_CTRL_PERF_EN
  logic [15:0] perf0_rd, perf0_wr, perf0_stall;
  logic [15:0] perf1_rd, perf1_wr, perf1_stall;
`endif

  mem_access_controller #(.WAIT_CYCLES(W0)) u_dut0 (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus0)
`ifdef MEM_CTRL_PERF_EN
    ,
    .perf_rd_count    (perf0_rd),
    .perf_wr_count    (perf0_wr),
    .perf_stall_count (perf0_stall)
`endif
  );

  mem_access_controller #(.WAIT_CYCLES(W1)) u_dut1 (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus1)
`ifdef MEM_CTRL_PERF_EN
    ,
    .perf_rd_count    (perf1_rd),
    .perf_wr_count    (perf1_wr),
    .perf_stall_count (perf1_stall)
`endif
  );

  function automatic logic [15:0] init_word(input int i);
    if (i == 0) return 16'h5678;
    if (i == 1) return 16'h1234;
    return 16'(i * 257) ^ 16'hA5A5;
  endfunction

  // SRAM models, written by the DUT strobes and reloaded on reset.
  logic [15:0] sram0 [64];
  logic [15:0] sram1 [64];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        sram0[i] <= init_word(i);
        sram1[i] <= init_word(i);
      end
    end else begin
      if (!bus0.sram_we_n) sram0[bus0.sram_addr[5:0]] <= bus0.sram_dq_out;
      if (!bus1.sram_we_n) sram1[bus1.sram_addr[5:0]] <= bus1.sram_dq_out;
    end
  end

  assign bus0.sram_dq_in = bus0.sram_oe_n ? 16'h0000 : sram0[bus0.sram_addr[5:0]];
  assign bus1.sram_dq_in = bus1.sram_oe_n ? 16'h0000 : sram1[bus1.sram_addr[5:0]];

  // Bench reference state.
  logic [15:0] ref0 [64];
  logic [15:0] ref1 [64];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reload_refs();
    for (int i = 0; i < 64; i++) begin
      ref0[i] = init_word(i);
      ref1[i] = init_word(i);
    end
    last_rd0 = 32'h0;
  endtask

  function automatic logic [16:0] idx_of(input logic [31:0] addr);
    logic [31:0] diff;
    diff = addr - 32'd1024;
    return diff[18:2];
  endfunction

  // One access on the W=2 instance, checked every cycle from acceptance (c=0)
  // to DONE (c=2W+1). With hold set, the request stays up into the next cycle.
  task automatic run0(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                      input bit hold);
    logic [16:0] idx;
    logic [5:0]  lo_i, hi_i;
    logic        active, hi;
    logic [31:0] word;
    idx  = idx_of(addr);
    lo_i = {idx[4:0], 1'b0};
    hi_i = {idx[4:0], 1'b1};
    if (is_wr) begin
      ref0[lo_i] = data[15:0];
      ref0[hi_i] = data[31:16];
    end else begin
      exp_q.push_back({ref0[hi_i], ref0[lo_i]});
    end
    bus0.rd_en      = !is_wr;
    bus0.wr_en      = is_wr;
    bus0.address    = addr;
    bus0.write_data = data;
    for (int c = 0; c <= 2 * W0 + 1; c++) begin
      #1;
      active = (c >= 1) && (c <= 2 * W0);
      hi     = (c > W0);
      check("freeze", 32'(bus0.freeze), 32'(c <= 2 * W0));
      check("ready", 32'(bus0.ready), 32'(c == 2 * W0 + 1));
      check("we_n", 32'(bus0.sram_we_n), 32'(!(active && is_wr)));
      check("oe_n", 32'(bus0.sram_oe_n), 32'(!(active && !is_wr)));
      check("dq_oe", 32'(bus0.sram_dq_oe), 32'(active && is_wr));
      if (active) check("sram_addr", 32'(bus0.sram_addr), 32'({idx, hi}));
      if (active && is_wr) check("dq_out", 32'(bus0.sram_dq_out), hi ? 32'(data[31:16])
                                                                     : 32'(data[15:0]));
      if (c == 2 * W0 + 1) begin
        if (is_wr) begin
          check("rd_hold", bus0.read_data, last_rd0);
        end else if (exp_q.size() == 0) begin
          check("sb_underflow", 32'h0, 32'h1);
        end else begin
          word     = exp_q.pop_front();
          last_rd0 = word;
          check("read_data", bus0.read_data, word);
        end
      end
      tick();
    end
    if (!hold) begin
      bus0.rd_en = 1'b0;
      bus0.wr_en = 1'b0;
    end
  endtask

  // One access on the W=1 instance, waiting (bounded) for ready.
  task automatic run1(input bit is_wr, input logic [31:0] addr, input logic [31:0] data);
    logic [16:0] idx;
    logic [5:0]  lo_i, hi_i;
    bit          seen;
    idx  = idx_of(addr);
    lo_i = {idx[4:0], 1'b0};
    hi_i = {idx[4:0], 1'b1};
    if (is_wr) begin
      ref1[lo_i] = data[15:0];
      ref1[hi_i] = data[31:16];
    end else begin
      exp_q.push_back({ref1[hi_i], ref1[lo_i]});
    end
    bus1.rd_en      = !is_wr;
    bus1.wr_en      = is_wr;
    bus1.address    = addr;
    bus1.write_data = data;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus1.ready) begin
        seen = 1'b1;
        check("w1_latency", 32'(c), 32'(2 * W1 + 1));
        if (!is_wr) begin
          if (exp_q.size() == 0) check("w1_sb_underflow", 32'h0, 32'h1);
          else check("w1_read_data", bus1.read_data, exp_q.pop_front());
        end
      end
      tick();
      if (seen) break;
    end
    if (!seen) check("w1_timeout", 32'h0, 32'h1);
    bus1.rd_en = 1'b0;
    bus1.wr_en = 1'b0;
  endtask

  initial begin
    bus0.rd_en = 1'b0; bus0.wr_en = 1'b0; bus0.address = '0; bus0.write_data = '0;
    bus1.rd_en = 1'b0; bus1.wr_en = 1'b0; bus1.address = '0; bus1.write_data = '0;
    reload_refs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_read_data", bus0.read_data, 32'h0);
    check("rst_we_n", 32'(bus0.sram_we_n), 32'h1);
    check("rst_oe_n", 32'(bus0.sram_oe_n), 32'h1);
    check("rst_dq_oe", 32'(bus0.sram_dq_oe), 32'h0);
    check("rst_sram_addr", 32'(bus0.sram_addr), 32'h0);
    check("rst_dq_out", 32'(bus0.sram_dq_out), 32'h0);
    check("rst_ready", 32'(bus0.ready), 32'h1);
    check("rst_freeze", 32'(bus0.freeze), 32'h0);
    tick();

    run0(1'b0, 32'd1024, 32'h0, 1'b0);            // 0x12345678 from preload
    tick();
    run0(1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
    tick();
    run0(1'b0, 32'd1028, 32'h0, 1'b0);
    tick();
    run0(1'b0, 32'd1032, 32'h0, 1'b1);            // back-to-back, request held
    run0(1'b1, 32'd1036, 32'hCAFEF00D, 1'b0);
    run0(1'b0, 32'd1036, 32'h0, 1'b0);
    tick();
    run0(1'b1, 32'd1020, 32'h01234567, 1'b0);     // below base: index wraps to 0x1FFFF
    tick();
    run0(1'b0, 32'd1020, 32'h0, 1'b0);
    tick();

    // Reset in the HI phase of a write.
    bus0.wr_en      = 1'b1;
    bus0.address    = 32'd1064;
    bus0.write_data = 32'h0BADF00D;
    repeat (3) tick();
    #1;
    check("mid_we_n", 32'(bus0.sram_we_n), 32'h0);
    check("mid_sram_addr", 32'(bus0.sram_addr), 32'({idx_of(32'd1064), 1'b1}));
    rst        = 1'b1;
    bus0.wr_en = 1'b0;
    tick();
    #1;
    check("rstmid_we_n", 32'(bus0.sram_we_n), 32'h1);
    check("rstmid_dq_oe", 32'(bus0.sram_dq_oe), 32'h0);
    check("rstmid_freeze", 32'(bus0.freeze), 32'h0);
    check("rstmid_ready", 32'(bus0.ready), 32'h1);
    check("rstmid_read_data", bus0.read_data, 32'h0);
    rst = 1'b0;
    reload_refs();
    tick();
    run0(1'b0, 32'd1024, 32'h0, 1'b0);            // fresh access after reset
    tick();

    // W=1: three reads then two writes.
    run1(1'b0, 32'd1024, 32'h0);
    run1(1'b0, 32'd1028, 32'h0);
    run1(1'b0, 32'd1032, 32'h0);
    run1(1'b1, 32'd1032, 32'h11112222);
    run1(1'b1, 32'd1024, 32'h33334444);
`ifdef MEM_CTRL_PERF_EN
    #1;
    check("perf_rd_count", 32'(perf1_rd), 32'd3);
    check("perf_wr_count", 32'(perf1_wr), 32'd2);
    check("perf_stall_count", 32'(perf1_stall), 32'd15);
`endif
    run1(1'b0, 32'd1032, 32'h0);
    run1(1'b0, 32'd1024, 32'h0);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
